// File: rtl/tdc_uart_tx.sv
// tdc_uart_tx: byte console transmitter; 16-entry FIFO feeding an 8N1 serialiser
// whose bit period (div_i, minimum 2) is latched at each pop.
module tdc_uart_tx #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 wr_en_i,
   input  logic [7:0]           wr_data_i,
   output logic                 full_o,
   output logic [DEPTH_LOG2:0]  level_o,
   output logic                 busy_o,
   output logic                 ovf_o,
   input  logic                 clr_ovf_i,
   output logic                 ser_tx_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  full_q, full_d;
   logic                  ovf_q, ovf_d;
   logic                  tx_q, tx_d;
   state_t                state_q, state_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d, cnt_q, cnt_d, eff_div;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            shift_q, shift_d;
   logic                  push, pop;

   assign eff_div = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
   assign push    = wr_en_i & ~full_q;
   assign pop     = (state_q == IDLE) && (level_q != '0);

   assign full_o   = full_q;
   assign level_o  = level_q;
   assign ovf_o    = ovf_q;
   assign ser_tx_o = tx_q;
   assign busy_o   = (state_q != IDLE) || (level_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      if (push && !pop)      level_d = level_q + (DEPTH_LOG2+1)'(1);
      else if (!push && pop) level_d = level_q - (DEPTH_LOG2+1)'(1);
      // a write against a full FIFO wins over a same-cycle clear
      if (wr_en_i && full_q) ovf_d = 1'b1;
      else if (clr_ovf_i)    ovf_d = 1'b0;
      full_d = level_d[DEPTH_LOG2];
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               div_d   = eff_div;
               cnt_d   = eff_div - DIV_WIDTH'(1);
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               cnt_d   = div_q - DIV_WIDTH'(1);
               state_d = DATA;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               cnt_d   = div_q - DIV_WIDTH'(1);
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         STOP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - DIV_WIDTH'(1);
         end
         default: state_d = IDLE;
      endcase
      // line level is registered from the next state, so no extra latency is added
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         tx_q     <= 1'b1;
         state_q  <= IDLE;
         div_q    <= DIV_WIDTH'(2);
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         tx_q     <= tx_d;
         state_q  <= state_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
      end
   end

endmodule

// File: tb/tb_tdc_uart_tx.sv
// tb_tdc_uart_tx: scoreboard bench; a line receiver pops expected {bit period, byte}
// entries and checks every cycle of each received frame.
module tb_tdc_uart_tx;

   localparam int unsigned DEPTH_LOG2 = 4;
   localparam int unsigned DIV_WIDTH  = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [DIV_WIDTH-1:0] div;
   logic                 wr_en;
   logic [7:0]           wr_data;
   logic                 clr_ovf;
   logic                 full, busy, ovf, ser;
   logic [DEPTH_LOG2:0]  level;

   tdc_uart_tx #(.DEPTH_LOG2(DEPTH_LOG2), .DIV_WIDTH(DIV_WIDTH)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .div_i    (div),
      .wr_en_i  (wr_en),
      .wr_data_i(wr_data),
      .full_o   (full),
      .level_o  (level),
      .busy_o   (busy),
      .ovf_o    (ovf),
      .clr_ovf_i(clr_ovf),
      .ser_tx_o (ser)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned div;
      logic [7:0]  data;
   } exp_t;

   exp_t        sb[$];
   int unsigned starts[$];
   int unsigned cyc = 0;
   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int unsigned frames = 0;
   bit          rx_abort = 1'b0;
   bit          rx_active = 1'b0;
   string       rx_str = "";

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin : receiver
      exp_t        e;
      logic [9:0]  fb;
      logic [7:0]  rx;
      int unsigned errs;
      bit          ab;
      forever begin
         @(negedge clk);
         if (!rst && ser === 1'b0) begin
            starts.push_back(cyc);
            if (sb.size() == 0) begin
               check("unexpected_start", 32'(ser), 32'd1);
               for (int w = 0; w < 100000 && ser === 1'b0; w++) @(negedge clk);
            end else begin
               e = sb.pop_front();
               fb = {1'b1, e.data, 1'b0};
               errs = 0;
               rx = '0;
               ab = 1'b0;
               rx_active = 1'b1;
               for (int k = 0; k < 10 && !ab; k++) begin
                  for (int c = 0; c < int'(e.div) && !ab; c++) begin
                     if (k != 0 || c != 0) @(negedge clk);
                     if (rx_abort) ab = 1'b1;
                     else begin
                        if (ser !== fb[k]) errs++;
                        if (k >= 1 && k <= 8 && c == int'(e.div / 2)) rx[k-1] = ser;
                     end
                  end
               end
               if (!ab) begin
                  check("frame_timing", 32'(errs), 32'd0);
                  check("rx_byte", 32'(rx), 32'(e.data));
                  rx_str = $sformatf("%s%c", rx_str, rx);
                  frames++;
               end
               rx_active = 1'b0;
            end
         end
      end
   end

   task automatic write(input logic [7:0] d, input int unsigned pop_div);
      wr_en = 1'b1;
      wr_data = d;
      sb.push_back('{pop_div, d});
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int unsigned budget);
      int unsigned n = 0;
      while ((sb.size() != 0 || rx_active || busy !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", 32'(n < budget), 32'd1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int unsigned lows;
      int unsigned fr_before;
      rst = 1'b1;
      div = 16'd4;
      wr_en = 1'b0;
      wr_data = '0;
      clr_ovf = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ser", 32'(ser), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single 0x55 frame, div 4: latency and busy release
      write(8'h55, 4);
      check("t1_level_after_write", 32'(level), 32'd1);
      check("t1_ser_pop_cycle", 32'(ser), 32'd1);
      @(negedge clk);
      check("t1_start_bit", 32'(ser), 32'd0);
      check("t1_level_after_pop", 32'(level), 32'd0);
      repeat (39) @(negedge clk);
      check("t1_busy_last_stop", 32'(busy), 32'd1);
      @(negedge clk);
      check("t1_busy_drop", 32'(busy), 32'd0);
      check("t1_ser_idle", 32'(ser), 32'd1);

      // three back-to-back bytes
      starts.delete();
      write(8'h41, 4);
      write(8'h42, 4);
      write(8'h43, 4);
      check("t2_level_peak", 32'(level), 32'd2);
      repeat (39) @(negedge clk);
      check("t2_level_before_pop2", 32'(level), 32'd2);
      @(negedge clk);
      check("t2_level_after_pop2", 32'(level), 32'd1);
      repeat (40) @(negedge clk);
      check("t2_level_before_pop3", 32'(level), 32'd1);
      @(negedge clk);
      check("t2_level_after_pop3", 32'(level), 32'd0);
      wait_drain(500);
      check("t2_frame_count", 32'(starts.size()), 32'd3);
      if (starts.size() == 3) begin
         check("t2_gap_1_2", 32'(starts[1] - starts[0]), 32'd41);
         check("t2_gap_2_3", 32'(starts[2] - starts[1]), 32'd41);
      end

      // fill to full, overflow, clear and clear-vs-set priority
      for (int i = 0; i < 17; i++) begin
         write(8'(8'h60 + i), 4);
         if (i == 15) check("t3_not_full_15", 32'(full), 32'd0);
      end
      check("t3_full", 32'(full), 32'd1);
      check("t3_level_full", 32'(level), 32'd16);
      check("t3_ovf_clear_before", 32'(ovf), 32'd0);
      wr_en = 1'b1;
      wr_data = 8'hEE;
      @(negedge clk);
      wr_en = 1'b0;
      check("t3_ovf_set", 32'(ovf), 32'd1);
      check("t3_level_after_drop", 32'(level), 32'd16);
      clr_ovf = 1'b1;
      @(negedge clk);
      check("t3_ovf_cleared", 32'(ovf), 32'd0);
      wr_en = 1'b1;
      wr_data = 8'hEF;
      @(negedge clk);
      wr_en = 1'b0;
      clr_ovf = 1'b0;
      check("t3_set_beats_clear", 32'(ovf), 32'd1);
      wait_drain(17 * 41 + 200);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("t3_ovf_final_clear", 32'(ovf), 32'd0);

      // div 1 behaves as 2; mid-frame div change applies to the next frame only
      starts.delete();
      div = 16'd1;
      write(8'h3C, 2);
      @(negedge clk);
      check("t4_start_bit", 32'(ser), 32'd0);
      div = 16'd8;
      write(8'hA5, 8);
      wait_drain(400);
      check("t4_frame_count", 32'(starts.size()), 32'd2);
      if (starts.size() == 2) check("t4_gap", 32'(starts[1] - starts[0]), 32'd21);

      // reset during a data bit with bytes queued
      div = 16'd4;
      fr_before = frames;
      write(8'h11, 4);
      write(8'h22, 4);
      write(8'h33, 4);
      repeat (4) @(negedge clk);
      rx_abort = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      check("t5_ser_after_rst", 32'(ser), 32'd1);
      check("t5_level_after_rst", 32'(level), 32'd0);
      check("t5_busy_after_rst", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      rx_abort = 1'b0;
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (ser !== 1'b1) lows++;
      end
      check("t5_line_quiet", 32'(lows), 32'd0);
      check("t5_no_frames", 32'(frames), 32'(fr_before));

      // console rate: ~115200 baud at 40 MHz
      rx_str = "";
      div = 16'd347;
      write(8'h4F, 347);
      write(8'h4B, 347);
      write(8'h0A, 347);
      wait_drain(3 * 3470 + 500);
      $display("console: %s", rx_str);
      check("t6_string_len", 32'(rx_str.len()), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
